// File: rtl/key_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : key_dispatcher
// Description : Dynamic chunk dispatcher for the parallel RC4 key-search
//               array. Grants contiguous key chunks round-robin to idle
//               cores, detects success/exhaustion/abort, captures the
//               winning key and core, and kills the cores when finished.
// Revision    : 1.0 - initial release
// ============================================================================
module key_dispatcher #(
  parameter int NUM_CORES     = 8,
  parameter int LOG_NUM_CORES = 3,
  parameter int KEY_WIDTH     = 24,
  parameter int CHUNK_LOG     = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [KEY_WIDTH-1:0]           key_lo,
  input  logic [KEY_WIDTH-1:0]           key_hi,
  input  logic [NUM_CORES-1:0]           core_req,
  input  logic [NUM_CORES-1:0]           core_found,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  output logic [NUM_CORES-1:0]           core_grant,
  output logic [KEY_WIDTH-1:0]           grant_base,
  output logic [KEY_WIDTH-1:0]           grant_last,
  output logic                           core_kill,
  output logic                           busy,
  output logic                           done,
  output logic                           success,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [LOG_NUM_CORES-1:0]       found_core,
  output logic [KEY_WIDTH-CHUNK_LOG:0]   chunks_issued
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_DISPATCH = 2'd1;
  localparam logic [1:0] c_DRAIN    = 2'd2;
  localparam logic [1:0] c_DONE     = 2'd3;

  // Chunk size kept one bit wider than a key so a wrap past all-ones shows
  // up in the carry bit of the next-base register.
  localparam logic [KEY_WIDTH:0]       c_CHUNK     = (KEY_WIDTH+1)'(1) << CHUNK_LOG;
  localparam logic [KEY_WIDTH:0]       c_CHUNK_M1  = c_CHUNK - (KEY_WIDTH+1)'(1);
  localparam logic [LOG_NUM_CORES:0]   c_NCORES    = (LOG_NUM_CORES+1)'(NUM_CORES);
  localparam logic [LOG_NUM_CORES:0]   c_IDX_ONE   = (LOG_NUM_CORES+1)'(1);
  localparam logic [NUM_CORES-1:0]     c_ONEHOT0   = {{(NUM_CORES-1){1'b0}}, 1'b1};
  localparam logic [KEY_WIDTH-CHUNK_LOG:0] c_CNT_ONE = (KEY_WIDTH-CHUNK_LOG+1)'(1);

  logic [1:0]                     r_state;
  logic [1:0]                     w_state_nxt;
  logic [KEY_WIDTH-1:0]           r_key_hi;
  logic [KEY_WIDTH:0]             r_next_base;
  logic [LOG_NUM_CORES-1:0]       r_rr_ptr;
  logic [NUM_CORES-1:0]           r_core_grant;
  logic [KEY_WIDTH-1:0]           r_grant_base;
  logic [KEY_WIDTH-1:0]           r_grant_last;
  logic                           r_core_kill;
  logic                           r_busy;
  logic                           r_done;
  logic                           r_success;
  logic [KEY_WIDTH-1:0]           r_found_key;
  logic [LOG_NUM_CORES-1:0]       r_found_core;
  logic [KEY_WIDTH-CHUNK_LOG:0]   r_chunks;

  logic                           w_any_found;
  logic [LOG_NUM_CORES-1:0]       w_fnd_idx;
  logic [NUM_CORES-1:0]           w_req_m;
  logic [LOG_NUM_CORES:0]         w_rr_sum;
  logic [LOG_NUM_CORES-1:0]       w_rr_idx;
  logic                           w_gnt_vld;
  logic [LOG_NUM_CORES-1:0]       w_gnt_idx;
  logic [LOG_NUM_CORES:0]         w_rr_inc;
  logic [LOG_NUM_CORES-1:0]       w_rr_nxt;
  logic                           w_range_ok;
  logic                           w_exhausted;
  logic [KEY_WIDTH:0]             w_chunk_end;
  logic [KEY_WIDTH-1:0]           w_grant_last;
  logic                           w_start_take;
  logic                           w_start_ok;
  logic                           w_do_grant;
  logic                           w_capture;

  assign w_any_found = |core_found;
  assign w_range_ok  = (key_lo <= key_hi);
  // A core whose grant pulse is still visible cannot win again this cycle.
  assign w_req_m     = core_req & ~r_core_grant;
  assign w_exhausted = r_next_base[KEY_WIDTH] | (r_next_base[KEY_WIDTH-1:0] > r_key_hi);
  assign w_chunk_end = r_next_base + c_CHUNK_M1;
  assign w_grant_last = (w_chunk_end > {1'b0, r_key_hi}) ? r_key_hi
                                                         : w_chunk_end[KEY_WIDTH-1:0];
  assign w_rr_inc    = {1'b0, w_gnt_idx} + c_IDX_ONE;
  assign w_rr_nxt    = (w_rr_inc == c_NCORES) ? '0 : w_rr_inc[LOG_NUM_CORES-1:0];

  // Lowest-index reporting core wins the capture.
  always_comb begin
    w_fnd_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_found[i]) w_fnd_idx = LOG_NUM_CORES'(i);
    end
  end

  // Round-robin search from r_rr_ptr upward, wrapping modulo NUM_CORES.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_rr_sum  = '0;
    w_rr_idx  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_rr_sum = {1'b0, r_rr_ptr} + (LOG_NUM_CORES+1)'(k);
      if (w_rr_sum >= c_NCORES) w_rr_sum = w_rr_sum - c_NCORES;
      w_rr_idx = w_rr_sum[LOG_NUM_CORES-1:0];
      if (!w_gnt_vld && w_req_m[w_rr_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_rr_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: found beats abort, abort beats exhaustion / drain completion.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      c_IDLE, c_DONE: begin
        if (start) w_state_nxt = w_range_ok ? c_DISPATCH : c_DONE;
      end
      c_DISPATCH: begin
        if (w_any_found)      w_state_nxt = c_DONE;
        else if (abort)       w_state_nxt = c_DONE;
        else if (w_exhausted) w_state_nxt = c_DRAIN;
      end
      c_DRAIN: begin
        if (w_any_found)      w_state_nxt = c_DONE;
        else if (abort)       w_state_nxt = c_DONE;
        else if (&core_req)   w_state_nxt = c_DONE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Control strobes derived from the current state and inputs.
  always_comb begin
    w_start_take = 1'b0;
    w_start_ok   = 1'b0;
    w_do_grant   = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      c_IDLE, c_DONE: begin
        w_start_take = start;
        w_start_ok   = start & w_range_ok;
      end
      c_DISPATCH: begin
        w_capture  = w_any_found;
        w_do_grant = ~w_any_found & ~abort & ~w_exhausted & w_gnt_vld;
      end
      c_DRAIN: begin
        w_capture = w_any_found;
      end
      default: ;
    endcase
  end

  // Registered datapath and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_hi     <= '0;
      r_next_base  <= '0;
      r_rr_ptr     <= '0;
      r_core_grant <= '0;
      r_grant_base <= '0;
      r_grant_last <= '0;
      r_core_kill  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_success    <= 1'b0;
      r_found_key  <= '0;
      r_found_core <= '0;
      r_chunks     <= '0;
    end else begin
      r_core_grant <= w_do_grant ? (c_ONEHOT0 << w_gnt_idx) : '0;
      r_busy       <= (w_state_nxt == c_DISPATCH) || (w_state_nxt == c_DRAIN);
      r_done       <= (w_state_nxt == c_DONE);
      r_core_kill  <= (w_state_nxt == c_IDLE) || (w_state_nxt == c_DONE);

      if (w_start_take) begin
        r_chunks     <= '0;
        r_found_key  <= '0;
        r_found_core <= '0;
        r_success    <= 1'b0;
      end
      if (w_start_ok) begin
        r_key_hi    <= key_hi;
        r_next_base <= {1'b0, key_lo};
      end
      if (w_do_grant) begin
        r_grant_base <= r_next_base[KEY_WIDTH-1:0];
        r_grant_last <= w_grant_last;
        r_next_base  <= r_next_base + c_CHUNK;
        r_chunks     <= r_chunks + c_CNT_ONE;
        r_rr_ptr     <= w_rr_nxt;
      end
      if (w_capture) begin
        r_success    <= 1'b1;
        r_found_core <= w_fnd_idx;
        r_found_key  <= core_key[w_fnd_idx*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

  assign core_grant    = r_core_grant;
  assign grant_base    = r_grant_base;
  assign grant_last    = r_grant_last;
  assign core_kill     = r_core_kill;
  assign busy          = r_busy;
  assign done          = r_done;
  assign success       = r_success;
  assign found_key     = r_found_key;
  assign found_core    = r_found_core;
  assign chunks_issued = r_chunks;

endmodule
`default_nettype wire

// File: tb/tb_key_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_dispatcher
// Description : Self-checking bench for key_dispatcher: directed scenarios
//               plus randomized searches against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_dispatcher;

  localparam int NC  = 4;
  localparam int LNC = 2;
  localparam int KW  = 24;
  localparam int CL  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, abort;
  logic [KW-1:0]     key_lo, key_hi;
  logic [NC-1:0]     core_req, core_found;
  logic [NC*KW-1:0]  core_key;
  logic [NC-1:0]     core_grant;
  logic [KW-1:0]     grant_base, grant_last;
  logic              core_kill, busy, done, success;
  logic [KW-1:0]     found_key;
  logic [LNC-1:0]    found_core;
  logic [KW-CL:0]    chunks_issued;

  always #5 clk = ~clk;

  key_dispatcher #(.NUM_CORES(NC), .LOG_NUM_CORES(LNC), .KEY_WIDTH(KW), .CHUNK_LOG(CL)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .key_lo(key_lo), .key_hi(key_hi), .core_req(core_req), .core_found(core_found),
    .core_key(core_key), .core_grant(core_grant), .grant_base(grant_base),
    .grant_last(grant_last), .core_kill(core_kill), .busy(busy), .done(done),
    .success(success), .found_key(found_key), .found_core(found_core),
    .chunks_issued(chunks_issued)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: phase 0=idle 1=handing out chunks 2=waiting for cores 3=finished
  int            m_phase;
  longint        m_next, m_hi, m_gbase, m_glast, m_fkey;
  int            m_rr, m_chunks, m_fcore;
  logic [NC-1:0] m_grant;
  bit            m_success;

  int     hold_cnt [NC];
  int     hold_min, hold_max;
  int     n_grants;
  longint last_glast;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_phase = 0; m_next = 0; m_hi = 0; m_gbase = 0; m_glast = 0; m_fkey = 0;
    m_rr = 0; m_chunks = 0; m_fcore = 0; m_grant = '0; m_success = 0;
  endfunction

  task automatic model_update();
    int            np, win, c;
    logic [NC-1:0] ng;
    longint        chunk;
    chunk = longint'(1) << CL;
    ng = '0; np = m_phase; win = -1;
    if (m_phase == 0 || m_phase == 3) begin
      if (start) begin
        m_chunks = 0; m_success = 0; m_fcore = 0; m_fkey = 0;
        if (key_lo <= key_hi) begin m_hi = key_hi; m_next = key_lo; np = 1; end
        else np = 3;
      end
    end else if (core_found != '0) begin
      for (int i = NC - 1; i >= 0; i--) if (core_found[i]) m_fcore = i;
      m_fkey = core_key[m_fcore*KW +: KW];
      m_success = 1; np = 3;
    end else if (abort) begin
      np = 3;
    end else if (m_phase == 1) begin
      if (m_next > m_hi) np = 2;
      else begin
        for (int k = 0; k < NC; k++) begin
          c = (m_rr + k) % NC;
          if (win < 0 && core_req[c] && !m_grant[c]) win = c;
        end
        if (win >= 0) begin
          ng[win] = 1'b1;
          m_gbase = m_next;
          m_glast = (m_next + chunk - 1 < m_hi) ? m_next + chunk - 1 : m_hi;
          m_next  = m_next + chunk;
          m_chunks++;
          m_rr = (win + 1) % NC;
        end
      end
    end else if (core_req == '1) begin
      np = 3;
    end
    m_grant = ng;
    m_phase = np;
  endtask

  task automatic compare_all();
    check_val("grant", core_grant, m_grant);
    if (m_grant != '0) begin
      check_val("grant_base", grant_base, m_gbase);
      check_val("grant_last", grant_last, m_glast);
    end
    check_val("busy", busy, (m_phase == 1 || m_phase == 2));
    check_val("done", done, (m_phase == 3));
    check_val("kill", core_kill, (m_phase == 0 || m_phase == 3));
    check_val("success", success, m_success);
    check_val("chunks", chunks_issued, m_chunks);
    check_val("found_core", found_core, m_fcore);
    check_val("found_key", found_key, m_fkey);
  endtask

  task automatic cores_update();
    for (int i = 0; i < NC; i++) begin
      if (m_grant[i]) begin
        hold_cnt[i] = $urandom_range(hold_max, hold_min);
        core_req[i] = 1'b0;
      end else if (hold_cnt[i] > 0) begin
        hold_cnt[i]--;
        if (hold_cnt[i] == 0) core_req[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    if (core_grant != '0) begin
      n_grants++;
      last_glast = grant_last;
    end
    start = 1'b0; abort = 1'b0; core_found = '0;
    cores_update();
  endtask

  task automatic do_start(input logic [KW-1:0] lo, input logic [KW-1:0] hi);
    key_lo = lo; key_hi = hi; start = 1'b1; n_grants = 0;
    tick();
  endtask

  task automatic run_until_done(input int budget, input bit rnd);
    int n = 0;
    while (m_phase != 3 && n < budget) begin
      if (rnd) begin
        core_key = {$urandom, $urandom, $urandom};
        if ($urandom_range(49, 0) == 0) core_found = NC'($urandom_range(15, 1));
        if ($urandom_range(59, 0) == 0) abort = 1'b1;
        if ($urandom_range(39, 0) == 0) start = 1'b1;
      end
      tick();
      n++;
    end
    check_val("reached_done", done, 1'b1);
  endtask

  task automatic release_cores();
    core_req = '1;
    for (int i = 0; i < NC; i++) hold_cnt[i] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int g;
    logic [KW-1:0] lo, hi, tmp;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    key_lo = '0; key_hi = '0; core_found = '0; core_key = '0;
    n_grants = 0; last_glast = 0;
    hold_min = 3; hold_max = 3;
    release_cores();
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check_val("rst_kill", core_kill, 1'b1);
    @(negedge clk) reset = 1'b1;

    // Basic exhaustion over 16 keys in four chunks
    do_start(24'd0, 24'd15);
    run_until_done(100, 0);
    check_val("basic_chunks", chunks_issued, 4);
    check_val("basic_grants", n_grants, 4);
    check_val("basic_success", success, 1'b0);

    // Top-of-range partial wrap: exactly two grants
    do_start(24'hFFFFF8, 24'hFFFFFF);
    run_until_done(100, 0);
    check_val("wrap_grants", n_grants, 2);
    check_val("wrap_last", last_glast, 24'hFFFFFF);

    // Success capture with two finders, lowest index wins
    core_key = {24'h123456, 24'h777777, 24'h00ABCD, 24'h555555};
    do_start(24'd0, 24'h00FFFF);
    repeat (3) tick();
    core_found = 4'b1010;
    tick();
    check_val("cap_done", done, 1'b1);
    check_val("cap_success", success, 1'b1);
    check_val("cap_core", found_core, 1);
    check_val("cap_key", found_key, 24'h00ABCD);
    check_val("cap_kill", core_kill, 1'b1);

    // Found and abort together
    do_start(24'd0, 24'h00FFFF);
    repeat (2) tick();
    core_found = 4'b0100; abort = 1'b1;
    tick();
    check_val("fa_success", success, 1'b1);
    check_val("fa_core", found_core, 2);

    // Found in the cycle exhaustion would be detected
    do_start(24'd0, 24'd7);
    g = 0;
    while (!(m_phase == 1 && m_next > m_hi) && g < 20) begin tick(); g++; end
    core_found = 4'b0001;
    tick();
    check_val("exh_success", success, 1'b1);
    check_val("exh_grant", core_grant, 0);
    check_val("exh_chunks", chunks_issued, 2);

    // Abort mid-dispatch, then restart from a new key_lo
    do_start(24'd0, 24'h00FFFF);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    check_val("abort_done", done, 1'b1);
    check_val("abort_success", success, 1'b0);
    check_val("abort_kill", core_kill, 1'b1);
    release_cores();
    do_start(24'd100, 24'd200);
    check_val("restart_chunks", chunks_issued, 0);
    g = 0;
    while (n_grants == 0 && g < 10) begin tick(); g++; end
    check_val("restart_base", grant_base, 100);
    abort = 1'b1;
    tick();

    // Invalid range
    do_start(24'd10, 24'd5);
    check_val("inv_done", done, 1'b1);
    check_val("inv_success", success, 1'b0);
    repeat (5) tick();
    check_val("inv_grants", n_grants, 0);

    // Asynchronous reset while a grant pulse is high
    release_cores();
    do_start(24'd0, 24'h00FFFF);
    g = 0;
    while (m_grant == '0 && g < 10) begin tick(); g++; end
    check_val("ar_pre_grant", (core_grant != '0), 1'b1);
    #2 reset = 1'b0;
    #1;
    check_val("ar_grant", core_grant, 0);
    check_val("ar_busy", busy, 1'b0);
    check_val("ar_kill", core_kill, 1'b1);
    m_reset();
    release_cores();
    @(negedge clk) reset = 1'b1;

    // Randomized searches
    hold_min = 1; hold_max = 4;
    for (int r = 0; r < 40; r++) begin
      lo = KW'($urandom);
      hi = lo + KW'($urandom_range(100, 0));
      if (hi < lo) hi = 24'hFFFFFF;
      if ($urandom_range(7, 0) == 0) begin tmp = lo; lo = hi + 24'd1; hi = tmp; end
      if ($urandom_range(5, 0) == 0) begin lo = 24'hFFFFFF - KW'($urandom_range(40, 0)); hi = 24'hFFFFFF; end
      core_key = {$urandom, $urandom, $urandom};
      do_start(lo, hi);
      run_until_done(400, 1);
      release_cores();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
